// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divide controller for the execute stage.
// Takes one signed/unsigned div or mod request at a time and holds the result until it is accepted.
module div_ctrl #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 div_enable,
  input  logic                 div_sign,
  input  logic                 div_rem,
  input  logic [DIV_WIDTH-1:0] div_src1,
  input  logic [DIV_WIDTH-1:0] div_src2,
  input  logic                 div_ack,
  input  logic                 flush,
  output logic                 div_complete,
  output logic [DIV_WIDTH-1:0] div_result,
  output logic                 div_busy,
  output logic [1:0]           div_state
);

  // Handshake: div_enable is a level request that must stay high until div_ack
  // is seen with div_complete high; the result and div_complete hold until then.
  localparam int CNT_W = $clog2(DIV_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, nxt;

  logic                 sign_q, rem_sel_q, s1_neg_q, s2_neg_q;
  logic [DIV_WIDTH-1:0] divisor_q, quo_q, rem_acc_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [DIV_WIDTH:0]   shifted, trial;
  logic [DIV_WIDTH-1:0] src1_abs, src2_abs, quo_fix, rem_fix;
  logic                 divisor_zero;
  logic                 start_op, step_op, fix_op, dz_op, clear_op;

  assign div_state = state;

  assign divisor_zero = (div_src2 == '0);
  assign src1_abs = (div_sign && div_src1[DIV_WIDTH-1]) ? -div_src1 : div_src1;
  assign src2_abs = (div_sign && div_src2[DIV_WIDTH-1]) ? -div_src2 : div_src2;

  // Partial remainder can reach 33 bits after the shift; the trial sign bit decides.
  assign shifted = {rem_acc_q, quo_q[DIV_WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_q};

  assign quo_fix = (sign_q && (s1_neg_q ^ s2_neg_q)) ? -quo_q : quo_q;
  assign rem_fix = (sign_q && s1_neg_q) ? -rem_acc_q : rem_acc_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (flush) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (div_enable) nxt = divisor_zero ? DONE : CALC;
        CALC: begin
          if (!div_enable)             nxt = IDLE;
          else if (cnt_q == LAST_ITER) nxt = FIX;
        end
        FIX:  nxt = div_enable ? DONE : IDLE;
        DONE: if (div_ack) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    start_op = (state == IDLE) && (nxt != IDLE);
    dz_op    = (state == IDLE) && (nxt == DONE);
    step_op  = (state == CALC) && (nxt != IDLE);
    fix_op   = (state == FIX)  && (nxt == DONE);
    clear_op = (nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_complete <= 1'b0;
      div_busy     <= 1'b0;
      div_result   <= '0;
      sign_q       <= 1'b0;
      rem_sel_q    <= 1'b0;
      s1_neg_q     <= 1'b0;
      s2_neg_q     <= 1'b0;
      divisor_q    <= '0;
      quo_q        <= '0;
      rem_acc_q    <= '0;
      cnt_q        <= '0;
    end else begin
      div_complete <= (nxt == DONE);
      div_busy     <= (nxt != IDLE);
      if (start_op) begin
        sign_q    <= div_sign;
        rem_sel_q <= div_rem;
        s1_neg_q  <= div_src1[DIV_WIDTH-1];
        s2_neg_q  <= div_src2[DIV_WIDTH-1];
        divisor_q <= src2_abs;
        quo_q     <= src1_abs;
        rem_acc_q <= '0;
        cnt_q     <= '0;
        // Divide by zero skips sign correction and reports the raw dividend as remainder.
        if (dz_op) div_result <= div_rem ? div_src1 : '1;
      end else if (step_op) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!trial[DIV_WIDTH]) begin
          rem_acc_q <= trial[DIV_WIDTH-1:0];
          quo_q     <= {quo_q[DIV_WIDTH-2:0], 1'b1};
        end else begin
          rem_acc_q <= shifted[DIV_WIDTH-1:0];
          quo_q     <= {quo_q[DIV_WIDTH-2:0], 1'b0};
        end
      end else if (fix_op) begin
        div_result <= rem_sel_q ? rem_fix : quo_fix;
      end else if (clear_op) begin
        cnt_q     <= '0;
        sign_q    <= 1'b0;
        rem_sel_q <= 1'b0;
        s1_neg_q  <= 1'b0;
        s2_neg_q  <= 1'b0;
      end
    end
  end

endmodule
